// File: rtl/multi_button_decoder.sv
// Synchronises and debounces NUM_BUTTONS push buttons, reporting each accepted
// press as a one-cycle pulse with a 1-based index plus a sticky selection.
module multi_button_decoder #(
  parameter int NUM_BUTTONS = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int MULTI_MODE  = 0,
  localparam int IDX_W      = $clog2(NUM_BUTTONS + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons,
  input  logic                   clear,
  output logic                   press_valid,
  output logic [IDX_W-1:0]       press_idx,
  output logic [IDX_W-1:0]       sel_idx,
  output logic                   multi_err,
  output logic                   busy
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [NUM_BUTTONS-1:0] ONE_B = NUM_BUTTONS'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  state_t                 state;
  logic [NUM_BUTTONS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_BUTTONS-1:0] s;
  logic [NUM_BUTTONS-1:0] cand;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W:0]         cnt_inc;
  logic                   cnt_hit;
  logic                   s_zero;
  logic                   multi_hot;
  logic [IDX_W-1:0]       low_idx;
  logic                   accept;
  logic                   take;
  logic                   reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= buttons;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign s_zero    = (s == '0);
  assign multi_hot = ((s & (s - ONE_B)) != '0);
  assign cnt_inc   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign cnt_hit   = (cnt_inc == (CNT_W + 1)'(DEBOUNCE));

  // Descending scan so the lowest set bit is the value left standing.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (s[i]) low_idx = IDX_W'(i + 1);
    end
  end

  always_comb begin
    accept = 1'b0;
    case (state)
      IDLE:     accept = !s_zero && (DEBOUNCE == 1);
      PRESS_DB: accept = !s_zero && (s == cand) && cnt_hit;
      default:  accept = 1'b0;
    endcase
  end

  assign take   = accept && (!multi_hot || (MULTI_MODE != 0));
  assign reject = accept && multi_hot && (MULTI_MODE == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cand        <= '0;
      cnt         <= '0;
      press_valid <= 1'b0;
      press_idx   <= '0;
      sel_idx     <= '0;
      multi_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      press_valid <= take;
      press_idx   <= take ? low_idx : '0;
      multi_err   <= reject;
      // An accept in the same cycle as clear must leave the new selection.
      if (take)       sel_idx <= low_idx;
      else if (clear) sel_idx <= '0;

      case (state)
        IDLE: begin
          if (!s_zero) begin
            cand  <= s;
            cnt   <= CNT_W'(1);
            state <= accept ? HELD : PRESS_DB;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        PRESS_DB: begin
          if (s_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (s != cand) begin
            cand <= s;
            cnt  <= CNT_W'(1);
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
            if (cnt_hit) state <= HELD;
          end
        end
        HELD: begin
          if (s_zero) begin
            cnt <= CNT_W'(1);
            if (DEBOUNCE == 1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= REL_DB;
            end
          end
        end
        REL_DB: begin
          if (!s_zero) begin
            state <= HELD;
          end else begin
            cnt <= cnt_inc[CNT_W-1:0];
            if (cnt_hit) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_button_decoder.sv
// Bench for multi_button_decoder: two instances (MULTI_MODE 0 and 1) share
// stimulus and are compared each cycle against a run-length reference model.
module tb_multi_button_decoder;

  localparam int NB          = 4;
  localparam int SYNC_STAGES = 2;
  localparam int DEBOUNCE    = 4;
  localparam int IDX_W       = $clog2(NB + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic [NB-1:0]    buttons = '0;
  logic             pv0, err0, busy0, pv1, err1, busy1;
  logic [IDX_W-1:0] idx0, sel0, idx1, sel1;

  int n_checks = 0;
  int n_fail   = 0;

  multi_button_decoder #(.NUM_BUTTONS(NB), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .MULTI_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .buttons(buttons), .clear(clear),
    .press_valid(pv0), .press_idx(idx0), .sel_idx(sel0), .multi_err(err0), .busy(busy0)
  );

  multi_button_decoder #(.NUM_BUTTONS(NB), .SYNC_STAGES(SYNC_STAGES), .DEBOUNCE(DEBOUNCE), .MULTI_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .buttons(buttons), .clear(clear),
    .press_valid(pv1), .press_idx(idx1), .sel_idx(sel1), .multi_err(err1), .busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference model: delay line for the synchroniser, then run lengths of
  // identical samples decide acceptance (armed) and release (disarmed).
  logic [NB-1:0]    dly [$];
  logic [NB-1:0]    s_m;
  logic [NB-1:0]    run_val = '0;
  int               run_len = 0;
  bit               armed = 1'b1;
  logic             e_pv0 = 1'b0, e_err0 = 1'b0, e_pv1 = 1'b0, e_busy = 1'b0;
  logic [IDX_W-1:0] e_idx0 = '0, e_sel0 = '0, e_idx1 = '0, e_sel1 = '0;

  wire [8:0] obs0 = {pv0, idx0, sel0, err0, busy0};
  wire [8:0] obs1 = {pv1, idx1, sel1, err1, busy1};
  wire [8:0] exp0 = {e_pv0, e_idx0, e_sel0, e_err0, e_busy};
  wire [8:0] exp1 = {e_pv1, e_idx1, e_sel1, 1'b0, e_busy};

  function automatic logic [IDX_W-1:0] lowest(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return IDX_W'(i + 1);
    return '0;
  endfunction

  always @(posedge clk) begin
    e_pv0 = 1'b0; e_err0 = 1'b0; e_pv1 = 1'b0; e_idx0 = '0; e_idx1 = '0;
    if (rst) begin
      dly = {};
      for (int i = 0; i < SYNC_STAGES; i++) dly.push_back('0);
      armed = 1'b1; run_len = 0; run_val = '0;
      e_sel0 = '0; e_sel1 = '0; e_busy = 1'b0;
    end else begin
      dly.push_back(buttons);
      s_m = dly.pop_front();
      if (clear) begin e_sel0 = '0; e_sel1 = '0; end
      if (armed) begin
        if (s_m == '0) run_len = 0;
        else if (run_len > 0 && s_m == run_val) run_len++;
        else begin run_val = s_m; run_len = 1; end
        if (run_len == DEBOUNCE) begin
          armed = 1'b0; run_len = 0;
          if ($countones(s_m) == 1) begin
            e_pv0 = 1'b1; e_idx0 = lowest(s_m); e_sel0 = lowest(s_m);
          end else begin
            e_err0 = 1'b1;
          end
          e_pv1 = 1'b1; e_idx1 = lowest(s_m); e_sel1 = lowest(s_m);
        end
      end else begin
        if (s_m == '0) run_len++; else run_len = 0;
        if (run_len == DEBOUNCE) begin armed = 1'b1; run_len = 0; end
      end
      e_busy = armed ? (run_len > 0) : 1'b1;
    end
  end

  task automatic test_reset();
    rst = 1'b1; buttons = '0; clear = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs0 !== 9'b0 || obs1 !== 9'b0) begin
      n_fail++; $display("[TB] FAIL reset_state got0=%b got1=%b want=000000000", obs0, obs1);
    end
    rst = 1'b0;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL reset_idle t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
    end
  endtask

  task automatic test_single_press();
    buttons = 4'b0100;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL single_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      n_checks++;
      if (pv0 !== (e == 5) || idx0 !== ((e == 5) ? 3'd3 : 3'd0)) begin
        n_fail++; $display("[TB] FAIL single_latency edge=%0d got pv=%b idx=%0d want pv=%b", e, pv0, idx0, (e == 5));
      end
    end
    n_checks++;
    if (sel0 !== 3'd3 || sel1 !== 3'd3) begin
      n_fail++; $display("[TB] FAIL single_sel got %0d/%0d want 3", sel0, sel1);
    end
    buttons = '0;
    for (int e = 0; e < 10; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL release_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      n_checks++;
      if (busy0 !== (e < 5)) begin
        n_fail++; $display("[TB] FAIL release_busy edge=%0d got %b want %b", e, busy0, (e < 5));
      end
    end
  endtask

  task automatic test_multi();
    int n_pv0 = 0, n_err0 = 0, n_pv1 = 0;
    logic [IDX_W-1:0] got_idx1 = '0;
    buttons = 4'b0011;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL multi_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      if (pv0) n_pv0++;
      if (err0) n_err0++;
      if (pv1) begin n_pv1++; got_idx1 = idx1; end
      if (e == 9) buttons = '0;
    end
    n_checks++;
    if (n_err0 != 1 || n_pv0 != 0 || sel0 !== 3'd3) begin
      n_fail++; $display("[TB] FAIL multi_mode0 got err=%0d pv=%0d sel=%0d want err=1 pv=0 sel=3", n_err0, n_pv0, sel0);
    end
    n_checks++;
    if (n_pv1 != 1 || got_idx1 !== 3'd1 || sel1 !== 3'd1) begin
      n_fail++; $display("[TB] FAIL multi_mode1 got pv=%0d idx=%0d sel=%0d want pv=1 idx=1 sel=1", n_pv1, got_idx1, sel1);
    end
  endtask

  task automatic test_hold_add();
    int n_a = 0, n_b = 0;
    logic [IDX_W-1:0] idx_a = '0, idx_b = '0;
    buttons = 4'b0010;
    for (int e = 0; e < 72; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL hold_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      if (e < 52 && (pv0 || pv1)) begin n_a++; idx_a = idx0; end
      if (e >= 52 && pv0) begin n_b++; idx_b = idx0; end
      if (e == 19) buttons = 4'b1010;
      if (e == 39) buttons = '0;
      if (e == 51) buttons = 4'b1000;
      if (e == 61) buttons = '0;
    end
    n_checks++;
    if (n_a != 1 || idx_a !== 3'd2) begin
      n_fail++; $display("[TB] FAIL hold_one_pulse got count=%0d idx=%0d want count=1 idx=2", n_a, idx_a);
    end
    n_checks++;
    if (n_b != 1 || idx_b !== 3'd4) begin
      n_fail++; $display("[TB] FAIL hold_next_press got count=%0d idx=%0d want count=1 idx=4", n_b, idx_b);
    end
  endtask

  task automatic test_clear();
    buttons = 4'b1000;
    for (int e = 0; e < 20; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL clear_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      if (e == 5) begin
        n_checks++;
        if (pv0 !== 1'b1 || sel0 !== 3'd4 || sel1 !== 3'd4) begin
          n_fail++; $display("[TB] FAIL clear_vs_accept got pv=%b sel=%0d/%0d want pv=1 sel=4", pv0, sel0, sel1);
        end
      end
      clear = (e == 4) || (e == 17);
      if (e == 9) buttons = '0;
    end
    n_checks++;
    if (sel0 !== 3'd0 || sel1 !== 3'd0) begin
      n_fail++; $display("[TB] FAIL clear_later got %0d/%0d want 0", sel0, sel1);
    end
  endtask

  task automatic test_bounce();
    int n_pv = 0, pv_edge = -1;
    logic [IDX_W-1:0] got_idx = '0;
    buttons = 4'b0001;
    for (int e = 0; e < 24; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL bounce_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      if (pv0) begin n_pv++; pv_edge = e; got_idx = idx0; end
      if (e == 0 || e == 2) buttons = '0;
      if (e == 1 || e == 3) buttons = 4'b0001;
      if (e == 13) buttons = '0;
    end
    n_checks++;
    if (n_pv != 1 || pv_edge != 9 || got_idx !== 3'd1) begin
      n_fail++; $display("[TB] FAIL bounce_pulse got count=%0d edge=%0d idx=%0d want count=1 edge=9 idx=1", n_pv, pv_edge, got_idx);
    end
  endtask

  task automatic test_reset_mid();
    int n_early = 0, n_late = 0;
    buttons = 4'b0010;
    for (int e = 0; e < 40; e++) begin
      @(negedge clk);
      n_checks++;
      if (obs0 !== exp0 || obs1 !== exp1) begin
        n_fail++; $display("[TB] FAIL rstmid_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
      end
      if (e == 4) begin
        n_checks++;
        if (obs0 !== 9'b0 || obs1 !== 9'b0) begin
          n_fail++; $display("[TB] FAIL rstmid_outputs got0=%b got1=%b want=000000000", obs0, obs1);
        end
      end
      if (e < 20 && (pv0 || pv1)) n_early++;
      if (e >= 20 && pv0) n_late++;
      rst = (e == 3);
      if (e == 5) buttons = '0;
      if (e == 19) buttons = 4'b0010;
      if (e == 31) buttons = '0;
    end
    n_checks++;
    if (n_early != 0 || n_late != 1) begin
      n_fail++; $display("[TB] FAIL rstmid_pulses got early=%0d late=%0d want early=0 late=1", n_early, n_late);
    end
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 300; seg++) begin
      int kind = $urandom_range(0, 9);
      int len  = (kind == 9) ? $urandom_range(1, 3) : $urandom_range(1, 12);
      if (kind < 2)      buttons = '0;
      else if (kind < 7) buttons = NB'(1) << $urandom_range(0, NB - 1);
      else               buttons = NB'($urandom_range(1, (1 << NB) - 1));
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        n_checks++;
        if (obs0 !== exp0 || obs1 !== exp1) begin
          n_fail++; $display("[TB] FAIL random_model t=%0t got0=%b want0=%b got1=%b want1=%b", $time, obs0, exp0, obs1, exp1);
        end
        clear = ($urandom_range(0, 7) == 0);
        rst   = ($urandom_range(0, 199) == 0);
      end
    end
    clear = 1'b0; rst = 1'b0; buttons = '0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_multi();
    test_hold_add();
    test_clear();
    test_bounce();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
